countdown_timer: RTL and testbench

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

---
 rtl/countdown_timer.sv | 165 ++++++++++++++++
 tb/tb_countdown_timer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// Hours/minutes/seconds BCD countdown timer driven by a go level from the setting stage.
// Counts down once per TICK_DIV clocks, pauses on go low and raises an alarm at zero.
module countdown_timer #(
    parameter int TICK_DIV = 100000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] preset,
    input  logic        go,
    output logic [31:0] disp,
    output logic        running,
    output logic        done,
    output logic        alarm
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, FINISH} state_t;

    typedef struct packed {
        logic [3:0] h10;
        logic [3:0] h1;
        logic [3:0] m10;
        logic [3:0] m1;
        logic [3:0] s10;
        logic [3:0] s1;
    } count_t;

    function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] lim);
        return (d > lim) ? lim : d;
    endfunction

    function automatic count_t load_preset(input logic [31:0] p);
        count_t c;
        c.h10 = clamp_digit(p[31:28], 4'd9);
        c.h1  = clamp_digit(p[27:24], 4'd9);
        c.m10 = clamp_digit(p[19:16], 4'd5);
        c.m1  = clamp_digit(p[15:12], 4'd9);
        c.s10 = clamp_digit(p[7:4],   4'd5);
        c.s1  = clamp_digit(p[3:0],   4'd9);
        return c;
    endfunction

    // One-second decrement; each digit borrows from the next only when it wraps.
    function automatic count_t dec_one(input count_t c);
        count_t r;
        r = c;
        if (c.s1 != 4'd0) r.s1 = c.s1 - 4'd1;
        else begin
            r.s1 = 4'd9;
            if (c.s10 != 4'd0) r.s10 = c.s10 - 4'd1;
            else begin
                r.s10 = 4'd5;
                if (c.m1 != 4'd0) r.m1 = c.m1 - 4'd1;
                else begin
                    r.m1 = 4'd9;
                    if (c.m10 != 4'd0) r.m10 = c.m10 - 4'd1;
                    else begin
                        r.m10 = 4'd5;
                        if (c.h1 != 4'd0) r.h1 = c.h1 - 4'd1;
                        else begin
                            r.h1  = 4'd9;
                            r.h10 = c.h10 - 4'd1;
                        end
                    end
                end
            end
        end
        return r;
    endfunction

    state_t        state, state_d;
    logic          go_q;
    logic          armed;
    logic [PW-1:0] presc, presc_d;
    count_t        cnt, cnt_d;
    logic          done_d;

    logic   go_rise;
    logic   tick;
    count_t loaded;
    count_t dec;

    // armed blocks a go that is already high when reset releases from counting as a rising edge.
    assign go_rise = go & ~go_q & armed;
    assign tick    = (presc == TICK_LAST);
    assign loaded  = load_preset(preset);
    assign dec     = dec_one(cnt);

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d = state;
        presc_d = presc;
        cnt_d   = cnt;
        done_d  = 1'b0;
        case (state)
            IDLE: begin
                if (go_rise) begin
                    cnt_d   = loaded;
                    presc_d = '0;
                    if (loaded == '0) begin
                        state_d = FINISH;
                        done_d  = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (tick) begin
                    cnt_d   = dec;
                    presc_d = '0;
                    if (dec == '0) begin
                        state_d = FINISH;
                        done_d  = 1'b1;
                    end else if (!go) begin
                        state_d = PAUSE;
                    end
                end else if (!go) begin
                    state_d = PAUSE;
                end else begin
                    presc_d = presc + PW'(1);
                end
            end
            PAUSE: begin
                if (go) state_d = RUN;
            end
            FINISH: begin
                if (!go) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            go_q  <= 1'b0;
            armed <= 1'b0;
            presc <= '0;
            cnt   <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_d;
            go_q  <= go;
            armed <= 1'b1;
            presc <= presc_d;
            cnt   <= cnt_d;
            done  <= done_d;
        end
    end

    always_comb begin
        if (state == IDLE)
            disp = {preset[31:24], 4'hF, preset[19:12], 4'hF, preset[7:0]};
        else
            disp = {cnt.h10, cnt.h1, 4'hF, cnt.m10, cnt.m1, 4'hF, cnt.s10, cnt.s1};
    end

    assign running = (state == RUN);
    assign alarm   = (state == FINISH);

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: directed scenarios plus random go/preset/reset traffic,
// all compared each cycle against a seconds-based reference model.
module tb_countdown_timer;

    localparam int TD = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] preset = '0;
    logic        go = 1'b0;
    logic [31:0] disp;
    logic        running, done, alarm;

    countdown_timer #(.TICK_DIV(TD)) dut (
        .clk(clk), .rst(rst), .preset(preset), .go(go),
        .disp(disp), .running(running), .done(done), .alarm(alarm)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: remaining time kept as a plain number of seconds.
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_FIN = 3;
    int m_mode = M_IDLE;
    int m_secs = 0;
    int m_phase = 0;
    bit m_goprev = 1'b0;
    bit m_armed = 1'b0;
    bit m_done = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int lim(input int d, input int m);
        return (d > m) ? m : d;
    endfunction

    function automatic int preset_secs(input logic [31:0] p);
        int h, m, s;
        h = lim(int'(p[31:28]), 9) * 10 + lim(int'(p[27:24]), 9);
        m = lim(int'(p[19:16]), 5) * 10 + lim(int'(p[15:12]), 9);
        s = lim(int'(p[7:4]), 5) * 10 + lim(int'(p[3:0]), 9);
        return h * 3600 + m * 60 + s;
    endfunction

    function automatic logic [31:0] show_secs(input int t);
        int h, m, s;
        h = t / 3600;
        m = (t / 60) % 60;
        s = t % 60;
        return {4'(h / 10), 4'(h % 10), 4'hF, 4'(m / 10), 4'(m % 10), 4'hF, 4'(s / 10), 4'(s % 10)};
    endfunction

    task automatic model_step();
        bit rise;
        bit nd;
        if (rst) begin
            m_mode = M_IDLE; m_secs = 0; m_phase = 0;
            m_goprev = 1'b0; m_armed = 1'b0; m_done = 1'b0;
            return;
        end
        rise = go && !m_goprev && m_armed;
        nd = 1'b0;
        case (m_mode)
            M_IDLE: if (rise) begin
                m_secs = preset_secs(preset);
                m_phase = 0;
                if (m_secs == 0) begin m_mode = M_FIN; nd = 1'b1; end
                else m_mode = M_RUN;
            end
            M_RUN: if (m_phase == TD - 1) begin
                m_secs--;
                m_phase = 0;
                if (m_secs == 0) begin m_mode = M_FIN; nd = 1'b1; end
                else if (!go) m_mode = M_PAUSE;
            end else if (!go) m_mode = M_PAUSE;
            else m_phase++;
            M_PAUSE: if (go) m_mode = M_RUN;
            default: if (!go) m_mode = M_IDLE;
        endcase
        m_goprev = go;
        m_armed = 1'b1;
        m_done = nd;
    endtask

    task automatic do_step(input logic go_v, input logic rst_v);
        logic [31:0] exp_disp;
        go = go_v;
        rst = rst_v;
        @(posedge clk);
        model_step();
        #1;
        exp_disp = (m_mode == M_IDLE) ? {preset[31:24], 4'hF, preset[19:12], 4'hF, preset[7:0]}
                                      : show_secs(m_secs);
        check("disp", disp, exp_disp);
        check("running", {31'b0, running}, {31'b0, m_mode == M_RUN});
        check("alarm", {31'b0, alarm}, {31'b0, m_mode == M_FIN});
        check("done", {31'b0, done}, {31'b0, m_done});
    endtask

    task automatic restart(input logic [31:0] p);
        preset = p;
        do_step(1'b0, 1'b1);
        do_step(1'b0, 1'b1);
        do_step(1'b0, 1'b0);
        do_step(1'b1, 1'b0);
    endtask

    initial begin
        // Reset state
        do_step(1'b0, 1'b1);
        check("rst_running", {31'b0, running}, 32'd0);
        check("rst_disp", disp, 32'h00F00F00);

        // 00:00:03 full run to alarm, then back to idle
        restart(32'h00F00F03);
        check("run_start", {31'b0, running}, 32'd1);
        for (int i = 0; i < 16; i++) do_step(1'b1, 1'b0);
        check("alarm_03", {31'b0, alarm}, 32'd1);
        do_step(1'b0, 1'b0);
        check("idle_back", {31'b0, alarm}, 32'd0);

        // Borrow across minutes and hours
        restart(32'h00F10F00);
        for (int i = 0; i < 4; i++) do_step(1'b1, 1'b0);
        check("borrow_min", disp, 32'h00F09F59);
        restart(32'h01F00F00);
        for (int i = 0; i < 4; i++) do_step(1'b1, 1'b0);
        check("borrow_hr", disp, 32'h00F59F59);
        restart(32'h10F00F00);
        for (int i = 0; i < 4; i++) do_step(1'b1, 1'b0);
        check("borrow_hr10", disp, 32'h09F59F59);

        // Pause mid-prescale, resume without reload
        restart(32'h00F00F05);
        for (int i = 0; i < 6; i++) do_step(1'b1, 1'b0);
        for (int i = 0; i < 20; i++) do_step(1'b0, 1'b0);
        check("pause_disp", disp, 32'h00F00F04);
        for (int i = 0; i < 6; i++) do_step(1'b1, 1'b0);

        // Clamp and zero preset
        restart(32'h00F00F7C);
        check("clamp", disp, 32'h00F00F59);
        restart(32'h00F00F00);
        check("zero_done", {31'b0, done}, 32'd1);
        check("zero_alarm", {31'b0, alarm}, 32'd1);

        // Reset mid-run with go held high: no restart until a fresh rising edge
        restart(32'h00F00F03);
        for (int i = 0; i < 4; i++) do_step(1'b1, 1'b0);
        do_step(1'b1, 1'b1);
        for (int i = 0; i < 6; i++) do_step(1'b1, 1'b0);
        check("no_restart", {31'b0, running}, 32'd0);
        do_step(1'b0, 1'b0);
        do_step(1'b1, 1'b0);
        check("restart", {31'b0, running}, 32'd1);

        // go falls in the tick that reaches zero
        restart(32'h00F00F01);
        for (int i = 0; i < 3; i++) do_step(1'b1, 1'b0);
        do_step(1'b0, 1'b0);
        check("fall_done", {31'b0, done}, 32'd1);
        check("fall_disp", disp, 32'h00F00F00);
        do_step(1'b0, 1'b0);
        check("fall_idle", {31'b0, alarm}, 32'd0);

        // Random traffic
        begin
            logic g;
            g = 1'b0;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, 11) == 0) g = ~g;
                if ($urandom_range(0, 19) == 0) begin
                    if ($urandom_range(0, 1) == 0)
                        preset = {8'h00, 4'hF, 8'h00, 4'hF, 4'($urandom_range(0, 1)), 4'($urandom_range(0, 12))};
                    else
                        preset = $urandom;
                end
                do_step(g, ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
